// File: rtl/alu_defs.sv
// Shared ALU function/special codes and arbiter state encoding.
package alu_defs;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SL  = 4'b0011;
  localparam logic [3:0] FN_SR  = 4'b0100;
  localparam logic [3:0] FN_STT = 4'b0101;
  localparam logic [3:0] FN_STF = 4'b0110;
  localparam logic [3:0] FN_SPC = 4'b0111;
  localparam logic [3:0] FN_SLW = 4'b1010;
  localparam logic [3:0] FN_SHG = 4'b1011;
  localparam logic [3:0] FN_BE  = 4'b1100;
  localparam logic [3:0] FN_BLT = 4'b1101;
  localparam logic [3:0] FN_UNK = 4'b1111;

  localparam logic [2:0] SP_INC  = 3'b000;
  localparam logic [2:0] SP_AND1 = 3'b001;
  localparam logic [2:0] SP_SUB8 = 3'b011;
  localparam logic [2:0] SP_PKR  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [3:0] func;
    logic [2:0] spec;
  } alu_ctl_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port not granted last.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_valid;
    if (&i_valid) o_grant = i_last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU between two requesters; issues one op at a time and
// returns the captured result as a single-cycle pulse to the granted port.
module alu_arbiter
  import alu_defs::*;
#(
  parameter int DATA_W  = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_reg1,
  input  logic [2*DATA_W-1:0] req_reg2,
  input  logic [7:0]          req_func,
  input  logic [5:0]          req_spec,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_res,
  output logic                rsp_carry,
  output logic                rsp_br,
  output logic [DATA_W-1:0]   alu_reg1,
  output logic [DATA_W-1:0]   alu_reg2,
  output logic [3:0]          alu_func,
  output logic [2:0]          alu_spec_fun,
  input  logic [DATA_W-1:0]   alu_res,
  input  logic                alu_carry,
  input  logic                alu_br,
  output logic                busy
);

  localparam int CNT_W = 2;

  arb_state_t        r_state, w_next;
  logic              r_last, r_gnt;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        w_grant;
  logic              w_accept, w_sel;
  logic [DATA_W-1:0] r_alu_reg1, r_alu_reg2, r_rsp_res;
  alu_ctl_t          r_ctl, w_ctl;
  logic [1:0]        r_rsp_valid;
  logic              r_rsp_carry, r_rsp_br;

  rr_arb2 u_rr (
    .i_valid (req_valid),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (|req_valid) w_next = ST_EXEC;
      ST_EXEC: if (r_cnt == '0) w_next = ST_CAPT;
      ST_CAPT: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == ST_IDLE) ? w_grant : 2'b00;
    busy      = (r_state != ST_IDLE);
  end

  assign w_accept = |(req_valid & req_ready);
  assign w_sel    = w_grant[1];
  assign w_ctl    = w_sel ? alu_ctl_t'{func: req_func[7:4], spec: req_spec[5:3]}
                          : alu_ctl_t'{func: req_func[3:0], spec: req_spec[2:0]};

  // Operand registers only change on acceptance, so the ALU sees a stable op
  // through EXEC/CAPT and the last op stays parked while idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last      <= 1'b1;
      r_gnt       <= 1'b0;
      r_cnt       <= '0;
      r_alu_reg1  <= '0;
      r_alu_reg2  <= '0;
      r_ctl       <= alu_ctl_t'{func: FN_STF, spec: SP_INC};
      r_rsp_valid <= 2'b00;
      r_rsp_res   <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_br    <= 1'b0;
    end else begin
      r_rsp_valid <= 2'b00;
      if (w_accept) begin
        r_alu_reg1 <= w_sel ? req_reg1[2*DATA_W-1:DATA_W] : req_reg1[DATA_W-1:0];
        r_alu_reg2 <= w_sel ? req_reg2[2*DATA_W-1:DATA_W] : req_reg2[DATA_W-1:0];
        r_ctl      <= w_ctl;
        r_gnt      <= w_sel;
        r_last     <= w_sel;
        r_cnt      <= CNT_W'(ALU_LAT - 1);
      end else if (r_state == ST_EXEC && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == ST_CAPT) begin
        r_rsp_res   <= alu_res;
        r_rsp_carry <= alu_carry;
        r_rsp_br    <= alu_br;
        r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
      end
    end
  end

  assign alu_reg1     = r_alu_reg1;
  assign alu_reg2     = r_alu_reg2;
  assign alu_func     = r_ctl.func;
  assign alu_spec_fun = r_ctl.spec;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_res      = r_rsp_res;
  assign rsp_carry    = r_rsp_carry;
  assign rsp_br       = r_rsp_br;

endmodule

// File: tb/tb_alu_arbiter.sv
// Drives two arbiters (ALU_LAT 1 and 3) with directed and random requests and
// compares every cycle against a transaction-level model of the arbiter.
module tb_alu_arbiter;

  typedef struct packed { logic [7:0] a; logic [7:0] b; logic [3:0] f; logic [2:0] s; } op_t;
  typedef struct packed { logic port; logic c; logic br; logic [7:0] res; } obs_t;

  logic clk, rst;
  logic [1:0]  v [2];
  logic [15:0] r1 [2], r2 [2];
  logic [7:0]  fn [2];
  logic [5:0]  sp [2];
  logic [1:0]  rdy [2], rv [2];
  logic [7:0]  rres [2], a1 [2], a2 [2], ares [2];
  logic        rc [2], rb [2], bz [2], acar [2], abr [2];
  logic [3:0]  af [2];
  logic [2:0]  as_ [2];
  logic [9:0]  pipe [2][4];

  int npass = 0, ntot = 0, nfail = 0, cyc = 0;
  op_t  q [4][$];
  obs_t obs_q [2][$];
  int   glog [2][$];
  int   busy_left [2], last [2], due [2];
  logic rsp_on [2], rsp_port [2], pend_port [2];
  logic [9:0] pend_val [2], held [2];
  op_t  alu_held [2];
  logic [1:0] eg_s [2], obs_ready [2];
  logic [3:0] fl [11] = '{4'b0000, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                          4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1111};

  alu_arbiter #(.DATA_W(8), .ALU_LAT(1)) u_dut0 (
    .clock(clk), .reset(rst), .req_valid(v[0]), .req_ready(rdy[0]),
    .req_reg1(r1[0]), .req_reg2(r2[0]), .req_func(fn[0]), .req_spec(sp[0]),
    .rsp_valid(rv[0]), .rsp_res(rres[0]), .rsp_carry(rc[0]), .rsp_br(rb[0]),
    .alu_reg1(a1[0]), .alu_reg2(a2[0]), .alu_func(af[0]), .alu_spec_fun(as_[0]),
    .alu_res(ares[0]), .alu_carry(acar[0]), .alu_br(abr[0]), .busy(bz[0]));

  alu_arbiter #(.DATA_W(8), .ALU_LAT(3)) u_dut1 (
    .clock(clk), .reset(rst), .req_valid(v[1]), .req_ready(rdy[1]),
    .req_reg1(r1[1]), .req_reg2(r2[1]), .req_func(fn[1]), .req_spec(sp[1]),
    .rsp_valid(rv[1]), .rsp_res(rres[1]), .rsp_carry(rc[1]), .rsp_br(rb[1]),
    .alu_reg1(a1[1]), .alu_reg2(a2[1]), .alu_func(af[1]), .alu_spec_fun(as_[1]),
    .alu_res(ares[1]), .alu_carry(acar[1]), .alu_br(abr[1]), .busy(bz[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {carry, br, res}
  function automatic logic [9:0] alu_ref(input logic [3:0] f, input logic [2:0] s,
                                         input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    logic [7:0] r;
    logic c, br;
    r = a ^ b; c = 1'b0; br = 1'b0;
    case (f)
      4'b0000: begin sum = {1'b0, a} + {1'b0, b}; r = sum[7:0]; c = sum[8]; end
      4'b0011: r = a << 1;
      4'b0100: r = a >> 1;
      4'b0101: r = b;
      4'b0110: r = a;
      4'b0111: case (s)
                 3'b000:  r = a + 8'd1;
                 3'b001:  r = a & 8'h01;
                 3'b011:  r = a - 8'd8;
                 3'b100:  r = {a[3:0], b[7:4]};
                 default: r = a;
               endcase
      4'b1010: r = a << 4;
      4'b1011: r = {a[3:0], b[3:0]};
      4'b1100: begin r = 8'h00; br = (a == b); end
      4'b1101: begin r = 8'h00; br = (a < b); end
      default: r = a ^ b;
    endcase
    return {c, br, r};
  endfunction

  // ALU model: output valid ALU_LAT edges after sampling
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pipe[d][0] <= alu_ref(af[d], as_[d], a1[d], a2[d]);
      for (int i = 1; i < 4; i++) pipe[d][i] <= pipe[d][i-1];
    end
  end
  assign {acar[0], abr[0], ares[0]} = pipe[0][0];
  assign {acar[1], abr[1], ares[1]} = pipe[1][2];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [1:0] exp_grant(input logic [1:0] vv, input int lst);
    if (vv == 2'b11) return (lst == 1) ? 2'b01 : 2'b10;
    return vv;
  endfunction

  function automatic op_t mk(input logic [3:0] f, input logic [2:0] s,
                             input logic [7:0] a, input logic [7:0] b);
    op_t o;
    o.a = a; o.b = b; o.f = f; o.s = s;
    return o;
  endfunction

  function automatic op_t mk_rand();
    return mk(fl[$urandom_range(0, 10)], 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] o, input logic [31:0] e);
    ntot++;
    assert (o === e) npass++;
    else begin
      nfail++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, o, e);
    end
  endtask

  task automatic model_reset(input int d);
    busy_left[d] = 0; last[d] = 1; due[d] = -1; rsp_on[d] = 1'b0;
    held[d] = '0; alu_held[d] = mk(4'b0110, 3'b000, 8'h00, 8'h00);
  endtask

  task automatic push(input int d, input int p, input op_t o);
    q[d*2+p].push_back(o);
  endtask

  task automatic push_both(input int p, input op_t o);
    push(0, p, o); push(1, p, o);
  endtask

  task automatic step(input bit rndm);
    op_t hd, o;
    int g;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        if (q[d*2+p].size() == 0) v[d][p] = 1'b0;
        else begin
          if (!rndm)        v[d][p] = 1'b1;
          else if (v[d][p]) v[d][p] = ($urandom_range(0, 7) != 0);
          else              v[d][p] = ($urandom_range(0, 1) == 1);
          hd = q[d*2+p][0];
          r1[d][p*8 +: 8] = hd.a;
          r2[d][p*8 +: 8] = hd.b;
          fn[d][p*4 +: 4] = hd.f;
          sp[d][p*3 +: 3] = hd.s;
        end
      end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      eg_s[d] = (busy_left[d] == 0) ? exp_grant(v[d], last[d]) : 2'b00;
      chk("req_ready", d, rdy[d], eg_s[d]);
      chk("busy", d, bz[d], busy_left[d] != 0);
      chk("rsp_valid", d, rv[d], rsp_on[d] ? (rsp_port[d] ? 2'b10 : 2'b01) : 2'b00);
      chk("rsp_res", d, rres[d], held[d][7:0]);
      chk("rsp_br", d, rb[d], held[d][8]);
      chk("rsp_carry", d, rc[d], held[d][9]);
      chk("alu_reg1", d, a1[d], alu_held[d].a);
      chk("alu_reg2", d, a2[d], alu_held[d].b);
      chk("alu_func", d, af[d], alu_held[d].f);
      chk("alu_spec", d, as_[d], alu_held[d].s);
      obs_ready[d] = rdy[d];
      if (rv[d] != 2'b00) obs_q[d].push_back({rv[d][1], rc[d], rb[d], rres[d]});
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst) model_reset(d);
      else begin
        rsp_on[d] = 1'b0;
        if (busy_left[d] > 0) busy_left[d]--;
        else if (eg_s[d] != 2'b00) begin
          g = eg_s[d][1] ? 1 : 0;
          o = q[d*2+g].pop_front();
          alu_held[d]  = o;
          last[d]      = g;
          busy_left[d] = lat(d) + 1;
          due[d]       = cyc + lat(d) + 2;
          pend_val[d]  = alu_ref(o.f, o.s, o.a, o.b);
          pend_port[d] = g[0];
          glog[d].push_back(g);
        end
        if (due[d] == cyc + 1) begin
          rsp_on[d] = 1'b1; held[d] = pend_val[d]; rsp_port[d] = pend_port[d]; due[d] = -1;
        end
      end
    end
    cyc++;
  endtask

  function automatic bit quiet(input int d);
    return q[d*2].size() == 0 && q[d*2+1].size() == 0 && busy_left[d] == 0 &&
           due[d] == -1 && !rsp_on[d];
  endfunction

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      done = quiet(0) && quiet(1);
      if (!done) step(1'b0);
    end
    done = quiet(0) && quiet(1);
    chk("drain", 0, done, 1);
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin obs_q[d].delete(); glog[d].delete(); end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      v[d] = '0; r1[d] = '0; r2[d] = '0; fn[d] = '0; sp[d] = '0;
      model_reset(d);
    end
    @(posedge clk); #1;
    step(1'b0);
    rst = 1'b0;

    // add with carry on port 0
    clear_logs();
    push_both(0, mk(4'b0000, 3'b000, 8'd200, 8'd100));
    drain();
    for (int d = 0; d < 2; d++) begin
      chk("add_cnt", d, obs_q[d].size(), 1);
      chk("add_res", d, obs_q[d][0].res, 8'd44);
      chk("add_carry", d, obs_q[d][0].c, 1'b1);
      chk("add_port", d, obs_q[d][0].port, 1'b0);
    end

    // round robin with both ports continuously valid, fresh from reset
    rst = 1'b1; step(1'b0); rst = 1'b0;
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      push_both(0, mk_rand());
      push_both(1, mk_rand());
    end
    drain();
    for (int d = 0; d < 2; d++) begin
      chk("rr_cnt", d, glog[d].size(), 8);
      for (int k = 0; k < 8; k++) chk("rr_order", d, glog[d][k], k % 2);
    end

    // single-port streaming of spec/inc on port 1
    clear_logs();
    push_both(1, mk(4'b0111, 3'b000, 8'hFF, 8'h00));
    push_both(1, mk(4'b0111, 3'b000, 8'h0F, 8'h00));
    push_both(1, mk(4'b0111, 3'b000, 8'h7F, 8'h00));
    drain();
    for (int d = 0; d < 2; d++) begin
      chk("inc_cnt", d, obs_q[d].size(), 3);
      chk("inc_res0", d, obs_q[d][0].res, 8'h00);
      chk("inc_res1", d, obs_q[d][1].res, 8'h10);
      chk("inc_res2", d, obs_q[d][2].res, 8'h80);
      chk("inc_port", d, {obs_q[d][0].port, obs_q[d][1].port, obs_q[d][2].port}, 3'b111);
    end

    // branch results on port 1
    clear_logs();
    push_both(1, mk(4'b1100, 3'b000, 8'h5A, 8'h5A));
    push_both(1, mk(4'b1101, 3'b000, 8'h03, 8'h02));
    drain();
    for (int d = 0; d < 2; d++) begin
      chk("br_be", d, obs_q[d][0].br, 1'b1);
      chk("br_blt", d, obs_q[d][1].br, 1'b0);
      chk("br_port", d, {obs_q[d][0].port, obs_q[d][1].port}, 2'b11);
    end

    // reset during EXEC aborts the op; then a tie goes to port 0
    clear_logs();
    push_both(1, mk(4'b0000, 3'b000, 8'h01, 8'h01));
    step(1'b0);
    rst = 1'b1; step(1'b0); rst = 1'b0;
    push_both(0, mk(4'b0000, 3'b000, 8'h10, 8'h20));
    push_both(1, mk(4'b0000, 3'b000, 8'h30, 8'h40));
    step(1'b0);
    for (int d = 0; d < 2; d++) chk("rst_first_grant", d, obs_ready[d], 2'b01);
    drain();
    for (int d = 0; d < 2; d++) begin
      chk("rst_rsp_cnt", d, obs_q[d].size(), 2);
      chk("rst_rsp0", d, obs_q[d][0].res, 8'h30);
      chk("rst_rsp1", d, obs_q[d][1].res, 8'h70);
    end

    // byte merge (longer latency exercised by dut1)
    clear_logs();
    push_both(0, mk(4'b1011, 3'b000, 8'h0A, 8'h05));
    drain();
    for (int d = 0; d < 2; d++) chk("shg_res", d, obs_q[d][0].res, 8'hA5);

    // random traffic with cancels and occasional resets
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++)
          if (q[d*2+p].size() < 3 && $urandom_range(0, 3) == 0) push(d, p, mk_rand());
      rst = ($urandom_range(0, 59) == 0);
      step(1'b1);
    end
    rst = 1'b0;
    drain();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit clocked ALU between two requesters, e.g. the PC/increment path (port 0) and the execute path (port 1).
- Grants round-robin with a valid/ready handshake.
- Drives the ALU operand and function inputs from registers and holds them stable for the ALU's registered latency.
- Captures res/carry_out/br_out and returns them to the granting requester as a one-cycle response pulse.

Parameters:
- DATA_W, 8, operand/result width (must match the ALU).
- ALU_LAT, 1, clock edges from ALU input sampling to valid ALU output; legal range 1..4.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  bit n = requester n has an operation pending.
- req_ready  out  2  bit n = requester n's operation accepted this cycle; one-hot or zero.
- req_reg1  in  2*DATA_W  {req1, req0} first operand.
- req_reg2  in  2*DATA_W  {req1, req0} second operand.
- req_func  in  8  {req1, req0} 4-bit ALU function code.
- req_spec  in  6  {req1, req0} 3-bit special-function code.
- rsp_valid  out  2  bit n = one-cycle pulse, response for requester n.
- rsp_res  out  DATA_W  captured ALU result.
- rsp_carry  out  1  captured carry_out.
- rsp_br  out  1  captured br_out.
- alu_reg1  out  DATA_W  to ALU reg1.
- alu_reg2  out  DATA_W  to ALU reg2.
- alu_func  out  4  to ALU func.
- alu_spec_fun  out  3  to ALU spec_fun.
- alu_res  in  DATA_W  from ALU res.
- alu_carry  in  1  from ALU carry_out.
- alu_br  in  1  from ALU br_out.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - state IDLE; last_grant = 1, so req0 wins first.
  - req_ready = 0, rsp_valid = 0, rsp_res = 0, rsp_carry = 0, rsp_br = 0.
  - alu_reg1 = 0, alu_reg2 = 0, alu_func = 4'b0110 (pass reg1), alu_spec_fun = 0.
- States:
  - IDLE -> EXEC when any req_valid is set.
  - EXEC holds for ALU_LAT cycles (down-counter), then -> CAPT.
  - CAPT -> IDLE unconditionally.
- Grant, computed combinationally in IDLE only:
  - Only one requester valid: grant it.
  - Both valid: grant ~last_grant.
  - req_ready = one-hot grant, asserted only in IDLE; 0 in EXEC and CAPT.
- Acceptance is req_valid[g] & req_ready[g] at the clock edge. On acceptance:
  - Latch that requester's reg1/reg2/func/spec into the alu_* registers.
  - Record g; set last_grant = g; load counter = ALU_LAT - 1.
- alu_* outputs are stable for all of EXEC and CAPT, and hold the last issued operation while IDLE (no toggling).
- In CAPT, register alu_res/alu_carry/alu_br into rsp_* and set rsp_valid[g] = 1 for exactly the following cycle.
- rsp_res/carry/br hold until the next capture.
- Latency: acceptance at edge E0 -> rsp_valid high in the cycle after edge E0+ALU_LAT+1, i.e. ALU_LAT+2 cycles.
- Back-to-back: a new grant may occur in the same IDLE cycle in which rsp_valid is high. Minimum issue period is ALU_LAT+2 cycles.
- Requester rules:
  - Must hold req_valid and payload stable until ready.
  - Dropping req_valid before ready is legal and cancels the request; no grant occurs.
  - Responses have no backpressure; requesters must sink rsp_valid.
- Function codes are passed through uninterpreted. Branch ops return their result on rsp_br; carry is meaningful only for add (4'b0000).
- Reset mid-operation (EXEC or CAPT): next cycle is IDLE, no rsp_valid is issued for the aborted op, and last_grant = 1.
- Reset overrides a simultaneous request.
- A requester re-asserting valid immediately after its response competes normally; fairness means neither port is starved for more than one grant when both are continuously valid.

Decomposition:
- Shared header/package alu_defs:
  - ALU func codes: add 0000, sl 0011, sr 0100, stt 0101, stf 0110, spec 0111, slw 1010, shg 1011, be 1100, blt 1101, unk 1111.
  - spec_fun codes: inc 000, and1 001, sub8 011, pkr 100.
  - Arbiter state encodings: IDLE 2'd0, EXEC 2'd1, CAPT 2'd2.
- One sub-module: rr_arb2, a combinational 2-way round-robin grant from req_valid and last_grant.

Test Plan:
All scenarios use a behavioural ALU model with ALU_LAT latency.
- Add with carry: ALU_LAT=1, req0 add 8'd200 + 8'd100 -> req_ready=01 in the accept cycle; rsp_valid=01 three cycles later with rsp_res=8'd44, rsp_carry=1; busy high for 2 cycles.
- Round-robin alternation: both requesters continuously valid, 4 ops each -> grant order 0,1,0,1,0,1,0,1; each rsp_valid bit matches its grant; rsp_res matches the issued operands.
- Single-port streaming: only req1 streams spec/inc with reg1=8'hFF, 8'h0F, ... -> accepted every 3 cycles; rsp_res=8'h00 then 8'h10; rsp_valid=10 only.
- Branch result: req1 be with 8'h5A == 8'h5A, then blt 8'h03 < 8'h02 -> rsp_br=1 then 0, both on rsp_valid[1].
- Reset mid-operation: reset asserted during EXEC -> no rsp_valid pulse; next cycle state IDLE, alu_func=4'b0110; with both then valid, req0 granted first.
- Longer latency: ALU_LAT=3, req0 shg 8'h0A, 8'h05 -> rsp_valid 5 cycles after acceptance, rsp_res=8'hA5; alu_* stable across EXEC and CAPT.
